// File: rtl/rename_table.sv
// Register alias table plus architectural register file between decode/issue and the ROB.
// Optional same-cycle commit bypass on lookups: define RENAME_TABLE_COMMIT_BYPASS_EN.
module rename_table #(
    parameter int GPR_ADDR_WIDTH = 5,
    parameter int WORD_WIDTH     = 32,
    parameter int PC_WIDTH       = 32,
    parameter int ROB_DEPTH      = 32,
    localparam int TW            = $clog2(ROB_DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      alloc_en,
    input  logic [TW-1:0]             alloc_tag,
    input  logic [GPR_ADDR_WIDTH-1:0] alloc_dst_addr,
    input  logic                      alloc_dst_wen,
    input  logic                      commit_en,
    input  logic [TW-1:0]             commit_tag,
    input  logic [GPR_ADDR_WIDTH-1:0] commit_dst_addr,
    input  logic                      commit_dst_wen,
    input  logic [WORD_WIDTH-1:0]     commit_dst_value,
    input  logic                      commit_br_taken,
    input  logic [PC_WIDTH-1:0]       commit_br_addr,
    input  logic                      commit_exp_en,
    input  logic [GPR_ADDR_WIDTH-1:0] rs1_addr,
    input  logic [GPR_ADDR_WIDTH-1:0] rs2_addr,
    output logic                      rs1_ready,
    output logic                      rs2_ready,
    output logic [WORD_WIDTH-1:0]     rs1_value,
    output logic [WORD_WIDTH-1:0]     rs2_value,
    output logic [TW-1:0]             rs1_tag,
    output logic [TW-1:0]             rs2_tag,
    output logic                      redirect_valid,
    output logic [PC_WIDTH-1:0]       redirect_pc,
    output logic [GPR_ADDR_WIDTH:0]   inflight_cnt
);

    localparam int NREG = 2 ** GPR_ADDR_WIDTH;

    logic [WORD_WIDTH-1:0]     r_arf     [NREG];
    logic [TW-1:0]             r_map_tag [NREG];
    logic [NREG-1:0]           r_busy;
    logic                      r_redirect_valid;
    logic [PC_WIDTH-1:0]       r_redirect_pc;
    logic [GPR_ADDR_WIDTH:0]   r_inflight_cnt;

    logic                      w_flush;
    logic                      w_alloc;
    logic                      w_commit_wr;
    logic [NREG-1:0]           w_busy_nxt;
    logic [GPR_ADDR_WIDTH:0]   w_cnt_nxt;
    logic [GPR_ADDR_WIDTH-1:0] w_rs_addr  [2];
    logic                      w_rs_ready [2];
    logic [WORD_WIDTH-1:0]     w_rs_value [2];
    logic [TW-1:0]             w_rs_tag   [2];

    assign w_flush     = commit_en && (commit_br_taken || commit_exp_en);
    // A flushing commit squashes everything younger, including this cycle's allocate.
    assign w_alloc     = alloc_en && alloc_dst_wen && (alloc_dst_addr != '0) && !w_flush;
    assign w_commit_wr = commit_en && commit_dst_wen && (commit_dst_addr != '0);

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_commit_wr && (r_map_tag[commit_dst_addr] == commit_tag))
            w_busy_nxt[commit_dst_addr] = 1'b0;
        if (w_alloc)
            w_busy_nxt[alloc_dst_addr] = 1'b1;
        if (w_flush)
            w_busy_nxt = '0;
        w_busy_nxt[0] = 1'b0;

        w_cnt_nxt = '0;
        for (int i = 0; i < NREG; i++)
            w_cnt_nxt = w_cnt_nxt + (GPR_ADDR_WIDTH+1)'(w_busy_nxt[i]);
    end

    // NOTE: the ARF and tag table are reset too, since lookups must read 0 right after reset.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_arf[i]     <= '0;
                r_map_tag[i] <= '0;
            end
            r_busy           <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_inflight_cnt   <= '0;
        end else begin
            if (w_commit_wr)
                r_arf[commit_dst_addr] <= commit_dst_value;
            if (w_alloc)
                r_map_tag[alloc_dst_addr] <= alloc_tag;
            r_busy           <= w_busy_nxt;
            r_inflight_cnt   <= w_cnt_nxt;
            r_redirect_valid <= w_flush;
            if (w_flush)
                r_redirect_pc <= commit_exp_en ? '0 : commit_br_addr;
        end
    end

    // Lookups read start-of-cycle state; a same-cycle allocate is deliberately invisible.
    always_comb begin
        w_rs_addr[0] = rs1_addr;
        w_rs_addr[1] = rs2_addr;
        for (int p = 0; p < 2; p++) begin
            w_rs_ready[p] = 1'b1;
            w_rs_value[p] = '0;
            w_rs_tag[p]   = '0;
            if (w_rs_addr[p] != '0) begin
                if (r_busy[w_rs_addr[p]]) begin
`ifdef RENAME_TABLE_COMMIT_BYPASS_EN
                    if (commit_en && commit_dst_wen && (r_map_tag[w_rs_addr[p]] == commit_tag)) begin
                        w_rs_value[p] = commit_dst_value;
                    end else begin
                        w_rs_ready[p] = 1'b0;
                        w_rs_tag[p]   = r_map_tag[w_rs_addr[p]];
                    end
`else
                    w_rs_ready[p] = 1'b0;
                    w_rs_tag[p]   = r_map_tag[w_rs_addr[p]];
`endif
                end else begin
                    w_rs_value[p] = r_arf[w_rs_addr[p]];
                end
            end
        end
    end

    assign rs1_ready      = w_rs_ready[0];
    assign rs2_ready      = w_rs_ready[1];
    assign rs1_value      = w_rs_value[0];
    assign rs2_value      = w_rs_value[1];
    assign rs1_tag        = w_rs_tag[0];
    assign rs2_tag        = w_rs_tag[1];
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign inflight_cnt   = r_inflight_cnt;

endmodule

// File: tb/tb_rename_table.sv
// Directed bench for rename_table: expectations are queued when stimulus is driven
// and popped against sampled DUT outputs.
module tb_rename_table;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alloc_en, alloc_dst_wen, commit_en, commit_dst_wen;
    logic        commit_br_taken, commit_exp_en;
    logic [4:0]  alloc_tag, alloc_dst_addr, commit_tag, commit_dst_addr;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] commit_dst_value, commit_br_addr;
    logic        rs1_ready, rs2_ready, redirect_valid;
    logic [31:0] rs1_value, rs2_value, redirect_pc;
    logic [4:0]  rs1_tag, rs2_tag;
    logic [5:0]  inflight_cnt;

    int          n_checks = 0;
    int          n_errors = 0;
    string       sb_name [$];
    logic [63:0] sb_val  [$];

    rename_table dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_en(alloc_en), .alloc_tag(alloc_tag), .alloc_dst_addr(alloc_dst_addr),
        .alloc_dst_wen(alloc_dst_wen),
        .commit_en(commit_en), .commit_tag(commit_tag), .commit_dst_addr(commit_dst_addr),
        .commit_dst_wen(commit_dst_wen), .commit_dst_value(commit_dst_value),
        .commit_br_taken(commit_br_taken), .commit_br_addr(commit_br_addr),
        .commit_exp_en(commit_exp_en),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_ready(rs1_ready), .rs2_ready(rs2_ready),
        .rs1_value(rs1_value), .rs2_value(rs2_value),
        .rs1_tag(rs1_tag), .rs2_tag(rs2_tag),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inflight_cnt(inflight_cnt)
    );

    always #5 clk = ~clk;

    // Lookup result packed as {ready, tag, value}; tag only matters while not ready.
    function automatic logic [63:0] lk(input logic r, input logic [4:0] t, input logic [31:0] v);
        return {26'd0, r, r ? 5'd0 : t, v};
    endfunction

    function automatic logic [63:0] obs1();
        return lk(rs1_ready, rs1_tag, rs1_value);
    endfunction

    function automatic logic [63:0] obs2();
        return lk(rs2_ready, rs2_tag, rs2_value);
    endfunction

    task automatic push(input string name, input logic [63:0] v);
        sb_name.push_back(name);
        sb_val.push_back(v);
    endtask

    task automatic check(input logic [63:0] obs);
        string       name;
        logic [63:0] exp;
        n_checks++;
        if (sb_val.size() == 0) begin
            n_errors++;
            $error("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            name = sb_name.pop_front();
            exp  = sb_val.pop_front();
            assert (obs === exp) else begin
                n_errors++;
                $error("FAIL %s observed=%h expected=%h", name, obs, exp);
            end
        end
    endtask

    task automatic idle();
        alloc_en        = 1'b0;
        alloc_dst_wen   = 1'b0;
        commit_en       = 1'b0;
        commit_dst_wen  = 1'b0;
        commit_br_taken = 1'b0;
        commit_exp_en   = 1'b0;
    endtask

    // Advance one clock; inputs return to idle on the falling edge, sample 1 ns later.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        idle();
        #1;
    endtask

    task automatic do_alloc(input logic [4:0] a, input logic [4:0] t);
        alloc_en       = 1'b1;
        alloc_dst_wen  = 1'b1;
        alloc_dst_addr = a;
        alloc_tag      = t;
    endtask

    task automatic do_commit(input logic [4:0] t, input logic [4:0] a, input logic w,
                             input logic [31:0] v);
        commit_en        = 1'b1;
        commit_tag       = t;
        commit_dst_addr  = a;
        commit_dst_wen   = w;
        commit_dst_value = v;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        alloc_tag = '0; alloc_dst_addr = '0; commit_tag = '0; commit_dst_addr = '0;
        commit_dst_value = '0; commit_br_addr = '0; rs1_addr = '0; rs2_addr = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Reset state
        rs1_addr = 5'd5; rs2_addr = 5'd0; #1;
        push("reset_rs1", lk(1, 0, 0));          check(obs1());
        push("reset_rs2", lk(1, 0, 0));          check(obs2());
        push("reset_inflight", 64'(6'd0));       check(64'(inflight_cnt));
        push("reset_redirect_valid", 64'(1'b0)); check(64'(redirect_valid));
        push("reset_redirect_pc", 64'(32'd0));   check(64'(redirect_pc));

        // Allocate x5 -> tag 3, then commit it
        do_alloc(5'd5, 5'd3);
        push("x5_busy", lk(0, 5'd3, 0));
        push("x5_inflight", 64'(6'd1));
        cycle();
        check(obs1()); check(64'(inflight_cnt));
        do_commit(5'd3, 5'd5, 1'b1, 32'hDEAD_BEEF);
        push("x5_committed", lk(1, 0, 32'hDEAD_BEEF));
        push("x5_inflight_after", 64'(6'd0));
        cycle();
        check(obs1()); check(64'(inflight_cnt));

        // Older commit must not release a younger mapping
        do_alloc(5'd7, 5'd1); cycle();
        do_alloc(5'd7, 5'd2); cycle();
        rs1_addr = 5'd7;
        do_commit(5'd1, 5'd7, 1'b1, 32'h11);
        push("x7_still_busy", lk(0, 5'd2, 0));
        push("x7_inflight", 64'(6'd1));
        cycle();
        check(obs1()); check(64'(inflight_cnt));
        do_commit(5'd2, 5'd7, 1'b1, 32'h22);
        push("x7_final", lk(1, 0, 32'h22));
        cycle();
        check(obs1());

        // Same-cycle allocate and commit on x9: allocate wins
        do_alloc(5'd9, 5'd0); cycle();
        do_alloc(5'd9, 5'd4);
        do_commit(5'd0, 5'd9, 1'b1, 32'h99);
        rs1_addr = 5'd9;
        push("x9_realloc", lk(0, 5'd4, 0));
        cycle();
        check(obs1());

        // Fill x3, x4, x8 then a taken-branch flush with an ignored same-cycle allocate
        do_alloc(5'd3, 5'd5); cycle();
        do_alloc(5'd4, 5'd6); cycle();
        do_alloc(5'd8, 5'd7); cycle();
        push("pre_flush_inflight", 64'(6'd4)); check(64'(inflight_cnt));
        do_commit(5'd8, 5'd1, 1'b1, 32'h40);
        commit_br_taken = 1'b1;
        commit_br_addr  = 32'h80;
        do_alloc(5'd10, 5'd9);
        rs1_addr = 5'd1; rs2_addr = 5'd9;
        push("flush_redirect_valid", 64'(1'b1));
        push("flush_redirect_pc", 64'(32'h80));
        push("flush_inflight", 64'(6'd0));
        push("flush_x1", lk(1, 0, 32'h40));
        push("flush_x9_arf", lk(1, 0, 32'h99));
        cycle();
        check(64'(redirect_valid)); check(64'(redirect_pc)); check(64'(inflight_cnt));
        check(obs1()); check(obs2());
        rs1_addr = 5'd10; rs2_addr = 5'd3; #1;
        push("flush_x10_ignored", lk(1, 0, 0)); check(obs1());
        push("flush_x3_clear", lk(1, 0, 0));    check(obs2());
        push("redirect_one_cycle", 64'(1'b0));
        cycle();
        check(64'(redirect_valid));

        // Exception beats branch, then back-to-back branch flush
        do_commit(5'd11, 5'd0, 1'b0, 32'h0);
        commit_exp_en = 1'b1; commit_br_taken = 1'b1; commit_br_addr = 32'h1234;
        push("exc_valid", 64'(1'b1));
        push("exc_pc", 64'(32'd0));
        cycle();
        check(64'(redirect_valid)); check(64'(redirect_pc));
        do_commit(5'd12, 5'd0, 1'b0, 32'h0);
        commit_br_taken = 1'b1; commit_br_addr = 32'h200;
        push("b2b_valid", 64'(1'b1));
        push("b2b_pc", 64'(32'h200));
        push("b2b_end", 64'(1'b0));
        cycle();
        check(64'(redirect_valid)); check(64'(redirect_pc));
        cycle();
        check(64'(redirect_valid));

        // x0 allocate is ignored
        do_alloc(5'd0, 5'd11);
        rs2_addr = 5'd0;
        push("x0_ready", lk(1, 0, 0));
        push("x0_inflight", 64'(6'd0));
        cycle();
        check(obs2()); check(64'(inflight_cnt));

        // Commit-cycle lookup of x6 (bypass is build dependent)
        do_alloc(5'd6, 5'd10); cycle();
        do_commit(5'd10, 5'd6, 1'b1, 32'h5A);
        rs1_addr = 5'd6;
`ifdef RENAME_TABLE_COMMIT_BYPASS_EN
        push("x6_commit_cycle", lk(1, 0, 32'h5A));
`else
        push("x6_commit_cycle", lk(0, 5'd10, 0));
`endif
        #1;
        check(obs1());
        push("x6_after", lk(1, 0, 32'h5A));
        cycle();
        check(obs1());

        // Reset mid-operation drops the pending redirect and clears the ARF
        do_commit(5'd13, 5'd11, 1'b1, 32'h77); cycle();
        do_alloc(5'd2, 5'd14); cycle();
        do_commit(5'd15, 5'd0, 1'b0, 32'h0);
        commit_br_taken = 1'b1; commit_br_addr = 32'h300;
        rs1_addr = 5'd11; rs2_addr = 5'd2;
        push("pre_reset_x11", lk(1, 0, 32'h77)); #1; check(obs1());
        push("pre_reset_x2", lk(0, 5'd14, 0));   check(obs2());
        push("pre_reset_redirect", 64'(1'b1));
        @(posedge clk); #1;
        check(64'(redirect_valid));
        idle();
        rst_n = 1'b0; #1;
        push("rst_redirect_valid", 64'(1'b0)); check(64'(redirect_valid));
        push("rst_redirect_pc", 64'(32'd0));   check(64'(redirect_pc));
        push("rst_x11", lk(1, 0, 0));           check(obs1());
        push("rst_inflight", 64'(6'd0));        check(64'(inflight_cnt));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        if (sb_val.size() != 0) begin
            n_checks++;
            n_errors++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb_val.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rename_table.md
# rename_table

Register alias table and architectural register file sitting between decode/issue and the reorder buffer. It consumes the ROB's allocate stream to map architectural destinations onto ROB tags, and consumes the ROB's commit stream to retire values into the architectural file and release mappings. It answers two combinational source-operand lookups per cycle and flash-clears all speculative mappings on a committed taken branch or exception. On such a flush it issues a registered front-end redirect.

## Interface
- `GPR_ADDR_WIDTH`, 5: architectural register index width (32 registers, x0 hardwired 0).
- `WORD_WIDTH`, 32: data width.
- `PC_WIDTH`, 32: redirect address width.
- `ROB_DEPTH`, 32: ROB entries; tag width `TW = $clog2(ROB_DEPTH)`.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `alloc_en` in 1: ROB allocates an entry this cycle.
- `alloc_tag` in TW: ROB tag of allocated entry.
- `alloc_dst_addr` in GPR_ADDR_WIDTH: architectural destination.
- `alloc_dst_wen` in 1: instruction writes a destination.
- `commit_en` in 1: ROB retires head this cycle.
- `commit_tag` in TW: tag of retiring entry.
- `commit_dst_addr` in GPR_ADDR_WIDTH: destination of retiring entry.
- `commit_dst_wen` in 1: retiring entry writes a register.
- `commit_dst_value` in WORD_WIDTH: retired value.
- `commit_br_taken` in 1: retiring entry is a taken branch.
- `commit_br_addr` in PC_WIDTH: branch target.
- `commit_exp_en` in 1: retiring entry raised an exception.
- `rs1_addr`, `rs2_addr` in GPR_ADDR_WIDTH: lookup addresses.
- `rs1_ready`, `rs2_ready` out 1: operand value available.
- `rs1_value`, `rs2_value` out WORD_WIDTH: operand value, valid when ready.
- `rs1_tag`, `rs2_tag` out TW: producing ROB tag, valid when not ready.
- `redirect_valid` out 1: one-cycle flush pulse to front end.
- `redirect_pc` out PC_WIDTH: redirect target.
- `inflight_cnt` out GPR_ADDR_WIDTH+1: number of mapped (busy) architectural registers.

## Operation
- State per register r: `arf[r]` (WORD_WIDTH), `busy[r]`, `map_tag[r]` (TW). Entry 0 is never written; `busy[0]` stays 0.
- Allocate: `alloc_en && alloc_dst_wen && alloc_dst_addr!=0` sets `busy[dst]` and `map_tag[dst] <= alloc_tag`, overwriting any older mapping.
- Commit: if `commit_en && commit_dst_wen && commit_dst_addr!=0`, then `arf[dst] <= commit_dst_value`. `busy[dst]` clears only if `map_tag[dst]==commit_tag`, i.e. no younger writer exists.
- Allocate and commit to the same register in the same cycle: the allocate wins, so `busy` stays 1 with the new tag. The ARF write still happens.
- Flush: the flush condition is `commit_en && (commit_br_taken || commit_exp_en)`. On flush:
  - All `busy` bits clear.
  - A same-cycle allocate is ignored.
  - The retiring instruction's own ARF write still happens.
- Redirect: `redirect_valid` pulses next cycle with `redirect_pc = commit_br_addr` for a branch. For an exception, `redirect_pc = 0`. Exception has priority when both are set.
- Lookup (combinational):
  - Address 0 gives ready=1, value=0.
  - Not busy gives ready=1, value=`arf[r]`.
  - Busy gives ready=0, tag=`map_tag[r]`, value=0.
  - See Configuration for the commit-cycle bypass.
- Lookups see state as of the start of the cycle. A same-cycle allocate is not visible to them; decode handles intra-group dependencies.
- `inflight_cnt` is a register updated every cycle to the popcount of the next-state `busy` vector.

## Timing
- Reset: all `arf`, `busy`, `map_tag` = 0; `redirect_valid`=0, `redirect_pc`=0, `inflight_cnt`=0. All lookups are ready with value 0.
- Allocate and commit updates are visible to lookups the cycle after the clock edge.
- Redirect latency: 1 cycle after the flush commit, held for exactly 1 cycle. Back-to-back flushes produce back-to-back pulses.
- Reset asserted mid-operation clears all state immediately. A pending redirect is dropped.
- Tags wrap modulo ROB_DEPTH. Correctness relies on the ROB never having two live entries with the same tag.

## Configuration
- `RENAME_TABLE_COMMIT_BYPASS_EN` defined: when a lookup hits a busy register whose `map_tag==commit_tag` with `commit_en && commit_dst_wen` this cycle, the lookup returns ready=1, value=`commit_dst_value` in the same cycle.
- Undefined: no bypass. That lookup returns ready=0 with the tag and becomes ready the following cycle.

## Test plan
- Reset, then look up rs1=5 and rs2=0 -> both ready=1, value 0; `inflight_cnt`=0.
- Allocate x5 with tag 3, then look up x5 next cycle -> ready=0, tag=3, `inflight_cnt`=1. Commit tag 3 with value 0xDEADBEEF -> next cycle ready=1, value 0xDEADBEEF, `inflight_cnt`=0.
- Allocate x7 with tag 1, then x7 with tag 2. Commit tag 1 with value 0x11 -> `arf[7]`=0x11 but x7 stays busy with tag 2. Commit tag 2 with value 0x22 -> ready, value 0x22.
- Same-cycle allocate of x9 with tag 4 and commit of x9 with tag 0 (mapped to tag 0) -> x9 busy with tag 4, `arf[9]` updated.
- With x3, x4, x8 busy, commit a taken branch with `commit_br_addr`=0x80 that writes x1=0x40 -> next cycle all registers ready, x1=0x40, `redirect_valid`=1 with `redirect_pc`=0x80 for one cycle, `inflight_cnt`=0.
- x6 mapped to tag 10; commit tag 10 with value 0x5A while looking up x6 -> with the bypass macro: same-cycle ready=1, value 0x5A. Without it: ready=0, tag 10, then ready the next cycle.
